// File: rtl/router_pkg.sv
// router_pkg: shared router types and sizing helpers
package router_pkg;
  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;
  function automatic int vc_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dp_ram.sv
// DP_RAM: simple dual-port RAM with one-cycle registered, reset-zeroed read
module DP_RAM #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              WR_CLK,
  input  logic              RD_CLK,
  input  logic              RSTn,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [WIDTH-1:0]  RD_DATA
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge WR_CLK)
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  always_ff @(posedge RD_CLK)
    if (!RSTn) RD_DATA <= '0;
    else if (RD_EN) RD_DATA <= mem[RD_ADDR];
endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel FIFOs sharing one statically partitioned RAM
module vc_fifo import router_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NUM_VC = 4,
  parameter int AF_LVL = DEPTH - 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int VC_W = vc_w(NUM_VC),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              WR_EN,
  input  logic [VC_W-1:0]   WR_VC,
  input  logic [WIDTH-1:0]  DATA_IN,
  input  logic              RD_EN,
  input  logic [VC_W-1:0]   RD_VC,
  output logic [WIDTH-1:0]  DATA_OUT,
  output logic              DATA_VLD,
  output logic [NUM_VC-1:0] FIFO_FULL,
  output logic [NUM_VC-1:0] FIFO_EMPTY,
  output logic [NUM_VC-1:0] ALMOST_FULL,
  output logic              OVF_ERR,
  output logic              UDF_ERR
);
  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [CNT_W-1:0] cnt [NUM_VC];
  logic wr_acc, rd_acc;
  fifo_err_t err;
  assign wr_acc = WR_EN && (32'(WR_VC) < NUM_VC) && !FIFO_FULL[WR_VC];
  assign rd_acc = RD_EN && (32'(RD_VC) < NUM_VC) && !FIFO_EMPTY[RD_VC];
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic w, r;
    assign w = wr_acc && WR_VC == VC_W'(v);
    assign r = rd_acc && RD_VC == VC_W'(v);
    always_ff @(posedge CLK)
      if (!RSTn) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v] <= '0;
      end else begin
        if (w) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (r) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        cnt[v] <= cnt[v] + CNT_W'(w) - CNT_W'(r);
      end
    assign FIFO_FULL[v] = cnt[v] == CNT_W'(DEPTH);
    assign FIFO_EMPTY[v] = cnt[v] == '0;
    assign ALMOST_FULL[v] = cnt[v] >= CNT_W'(AF_LVL);
  end
  always_ff @(posedge CLK)
    if (!RSTn) begin
      DATA_VLD <= 1'b0;
      err <= '0;
    end else begin
      DATA_VLD <= rd_acc;
      err.ovf <= err.ovf | (WR_EN & ~wr_acc);
      err.udf <= err.udf | (RD_EN & ~rd_acc);
    end
  assign OVF_ERR = err.ovf;
  assign UDF_ERR = err.udf;
  DP_RAM #(.WIDTH(WIDTH), .DEPTH(NUM_VC * DEPTH), .ADDR_W(VC_W + PTR_W)) u_ram (
    .WR_CLK(CLK),
    .RD_CLK(CLK),
    .RSTn(RSTn),
    .WR_EN(wr_acc),
    .WR_ADDR({WR_VC, wr_ptr[WR_VC]}),
    .WR_DATA(DATA_IN),
    .RD_EN(rd_acc),
    .RD_ADDR({RD_VC, rd_ptr[RD_VC]}),
    .RD_DATA(DATA_OUT)
  );
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed self-checking bench for vc_fifo
module tb_vc_fifo;
  logic CLK = 0, RSTn = 0;
  logic WR_EN = 0, RD_EN = 0;
  logic [1:0] WR_VC = 0, RD_VC = 0;
  logic [7:0] DATA_IN = 0, DATA_OUT;
  logic DATA_VLD, OVF_ERR, UDF_ERR;
  logic [3:0] FIFO_FULL, FIFO_EMPTY, ALMOST_FULL;
  int checks = 0, errors = 0;
  vc_fifo dut (
    .CLK(CLK), .RSTn(RSTn), .WR_EN(WR_EN), .WR_VC(WR_VC), .DATA_IN(DATA_IN),
    .RD_EN(RD_EN), .RD_VC(RD_VC), .DATA_OUT(DATA_OUT), .DATA_VLD(DATA_VLD),
    .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .OVF_ERR(OVF_ERR), .UDF_ERR(UDF_ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic we, input logic [1:0] wv, input logic [7:0] d,
                     input logic re, input logic [1:0] rv);
    WR_EN = we; WR_VC = wv; DATA_IN = d; RD_EN = re; RD_VC = rv;
    @(posedge CLK); #1;
    WR_EN = 0; RD_EN = 0;
  endtask
  initial begin
    repeat (2) cyc(0, 0, 0, 0, 0);
    RSTn = 1;
    chk("rst_empty", FIFO_EMPTY, 4'hF);
    chk("rst_full", FIFO_FULL, 0);
    chk("rst_af", ALMOST_FULL, 0);
    chk("rst_vld", DATA_VLD, 0);
    chk("rst_dout", DATA_OUT, 0);
    chk("rst_ovf", OVF_ERR, 0);
    chk("rst_udf", UDF_ERR, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 2, 8'(8'h10 + i), 0, 0);
      chk("fill_af2", ALMOST_FULL[2], (i + 1 >= 14) ? 1 : 0);
    end
    chk("fill_full", FIFO_FULL, 4'b0100);
    chk("fill_empty", FIFO_EMPTY, 4'b1011);
    chk("fill_af", ALMOST_FULL, 4'b0100);
    cyc(1, 2, 8'hEE, 0, 0);
    chk("ovf_set", OVF_ERR, 1);
    chk("ovf_full", FIFO_FULL, 4'b0100);
    chk("ovf_udf", UDF_ERR, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 2);
      chk("drain_vld", DATA_VLD, 1);
      chk("drain_data", DATA_OUT, 32'(8'h10 + i));
    end
    cyc(0, 0, 0, 0, 0);
    chk("idle_vld", DATA_VLD, 0);
    chk("idle_hold", DATA_OUT, 8'h1F);
    chk("drain_empty", FIFO_EMPTY, 4'hF);
    chk("drain_udf", UDF_ERR, 0);
    cyc(1, 0, 8'hA1, 0, 0);
    cyc(1, 1, 8'hB1, 0, 0);
    cyc(1, 0, 8'hA2, 0, 0);
    chk("il_empty", FIFO_EMPTY, 4'b1100);
    chk("il_full", FIFO_FULL, 0);
    cyc(0, 0, 0, 1, 1);
    chk("il_d0", DATA_OUT, 8'hB1);
    chk("il_empty1", FIFO_EMPTY, 4'b1110);
    cyc(0, 0, 0, 1, 0);
    chk("il_d1", DATA_OUT, 8'hA1);
    cyc(0, 0, 0, 1, 0);
    chk("il_d2", DATA_OUT, 8'hA2);
    chk("il_vld", DATA_VLD, 1);
    chk("il_done", FIFO_EMPTY, 4'hF);
    chk("il_ovf_sticky", OVF_ERR, 1);
    cyc(1, 3, 8'h33, 0, 0);
    cyc(1, 3, 8'h34, 1, 3);
    chk("sim3_data", DATA_OUT, 8'h33);
    chk("sim3_vld", DATA_VLD, 1);
    chk("sim3_empty", FIFO_EMPTY, 4'b0111);
    cyc(0, 0, 0, 1, 3);
    chk("sim3_next", DATA_OUT, 8'h34);
    chk("sim3_drained", FIFO_EMPTY, 4'hF);
    cyc(1, 0, 8'h55, 1, 0);
    chk("sim0_udf", UDF_ERR, 1);
    chk("sim0_vld", DATA_VLD, 0);
    chk("sim0_empty", FIFO_EMPTY, 4'b1110);
    cyc(0, 0, 0, 1, 0);
    chk("sim0_data", DATA_OUT, 8'h55);
    chk("sim0_drained", FIFO_EMPTY, 4'hF);
    RSTn = 0;
    cyc(0, 0, 0, 0, 0);
    RSTn = 1;
    chk("rst2_ovf", OVF_ERR, 0);
    chk("rst2_udf", UDF_ERR, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 48; i++) begin
      cyc(1, 1, 8'(8'h43 + i), 1, 1);
      chk("wrap_data", DATA_OUT, 32'(8'h40 + i));
    end
    chk("wrap_ovf", OVF_ERR, 0);
    chk("wrap_udf", UDF_ERR, 0);
    chk("wrap_empty", FIFO_EMPTY, 4'b1101);
    cyc(0, 0, 0, 1, 1);
    chk("mid_data", DATA_OUT, 8'h70);
    chk("mid_vld", DATA_VLD, 1);
    RSTn = 0;
    cyc(0, 0, 0, 0, 0);
    chk("mid_rst_vld", DATA_VLD, 0);
    chk("mid_rst_empty", FIFO_EMPTY, 4'hF);
    chk("mid_rst_dout", DATA_OUT, 0);
    RSTn = 1;
    cyc(0, 0, 0, 1, 1);
    chk("mid_udf", UDF_ERR, 1);
    chk("mid_read_vld", DATA_VLD, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
